// File: rtl/rv32i_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_encoder_if
//  Purpose  : Field-bundle input channel and encoded-word output channel of
//             the RV32I encoder, each with its own valid/ready handshake.
//             slave  = encoder side, master = producer/sink side.
//  Revision : 1.0  initial release
// ============================================================================
interface rv32i_encoder_if #(
  parameter int ADDR_W = 32
);
  // field bundle channel
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  // encoded word channel
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_encoder
//  Purpose  : Packs RV32I instruction fields into 32-bit machine words and
//             streams them out with byte addresses, one programmed burst per
//             start pulse. One register stage between the channels.
//  Options  : RV32I_ENC_RANGE_CHECK_EN - also flag immediates that do not
//             fit their instruction format (word is still emitted truncated).
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [ADDR_W-1:0] base_addr,
  input  wire logic [CNT_W-1:0]  count,
  output logic                   busy,
  output logic                   done,
  rv32i_encoder_if.slave         bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [1:0]        state;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] next_addr;
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_err_q;

  logic        accept;
  logic        xfer;
  logic [31:0] enc_word;
  logic        bad_class;
  logic        range_err;
  logic        shift_form;

  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;

  // Slot-immediate shift instructions carry funct7 in the upper imm bits.
  assign shift_form = (f3 == 3'b001) || (f3 == 3'b101);

  // Input is only open in RUN, and only when the output slot frees up.
  assign bus.in_ready = (state == RUN) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = out_valid_q && bus.out_ready;

  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;

  // Pack the current field bundle into its instruction format.
  always_comb begin
    enc_word  = 32'h0000_0000;
    bad_class = 1'b0;
    case (bus.in_class)
      4'd0: enc_word = {f7, rs2, rs1, f3, rd, OP_ALUREG};
      4'd1: begin
        if (shift_form) enc_word = {f7, imm[4:0], rs1, f3, rd, OP_ALUIMM};
        else            enc_word = {imm[11:0], rs1, f3, rd, OP_ALUIMM};
      end
      4'd2: enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      4'd3: enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      4'd4: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      4'd5: enc_word = {imm[31:12], rd, OP_AUIPC};
      4'd6: enc_word = {imm[31:12], rd, OP_LUI};
      4'd7: enc_word = {imm[11:0], rs1, f3, rd, OP_LOAD};
      4'd8: enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      4'd9: enc_word = {imm[11:0], rs1, f3, rd, OP_SYSTEM};
      default: bad_class = 1'b1;
    endcase
  end

`ifdef RV32I_ENC_RANGE_CHECK_EN
  logic i_bad, b_bad, j_bad, u_bad, sh_bad;
  // An immediate fits when all bits above its sign bit replicate that sign.
  assign i_bad  = !((&imm[31:11]) || !(|imm[31:11]));
  assign b_bad  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
  assign j_bad  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
  assign u_bad  = (imm[11:0] != 12'h000);
  assign sh_bad = (imm[11:5] != 7'h00);

  // Select the fit test that matches the format of the current class.
  always_comb begin
    range_err = 1'b0;
    case (bus.in_class)
      4'd1:             range_err = shift_form ? (sh_bad || i_bad) : i_bad;
      4'd3, 4'd7, 4'd9: range_err = i_bad;
      4'd8:             range_err = i_bad;
      4'd2:             range_err = b_bad;
      4'd4:             range_err = j_bad;
      4'd5, 4'd6:       range_err = u_bad;
      default:          range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // Burst control: latch the burst on start, count accepts, wait for drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= count;
            state     <= (count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= DRAIN;
          end
        end
        DRAIN:   if (xfer) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: load on accept, clear on transfer, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        next_addr <= base_addr;
      end else if (accept) begin
        next_addr <= next_addr + ADDR_W'(4);
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_instr_q <= enc_word;
        out_addr_q  <= next_addr;
        out_err_q   <= bad_class || range_err;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_encoder
//  Purpose  : Self-checking bench for rv32i_encoder: directed scenarios and
//             randomized bursts against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv32i_encoder;

`ifdef RV32I_ENC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        busy;
  logic        done;
  int          checks = 0;
  int          errors = 0;

  rv32i_encoder_if #(.ADDR_W(32)) bus ();

  rv32i_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference encoder: builds the word by weighting each field by its bit
  // position, with range tests written as signed numeric bounds.
  function automatic void model_enc(input int cls, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic [31:0] f7, input logic [31:0] imm,
      output logic [31:0] w, output logic err);
    int simm;
    logic [31:0] op;
    bit rng;
    simm = $signed(imm);
    rng  = 1'b0;
    w    = 32'h0;
    case (cls)
      0: op = 32'h33; 1: op = 32'h13; 2: op = 32'h63; 3: op = 32'h67;
      4: op = 32'h6F; 5: op = 32'h17; 6: op = 32'h37; 7: op = 32'h03;
      8: op = 32'h23; 9: op = 32'h73; default: op = 32'h0;
    endcase
    case (cls)
      0: w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
      1: begin
        if (f3 == 1 || f3 == 5) begin
          w   = f7 * 2**25 + (imm % 32) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
          rng = ((imm / 32) % 128) != 0 || simm < -2048 || simm > 2047;
        end else begin
          w   = (imm % 4096) * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + op;
          rng = simm < -2048 || simm > 2047;
        end
      end
      3, 7, 9: begin
        w   = (imm % 4096) * 2**20 + rs1 * 2**15 + (cls == 3 ? 0 : f3) * 2**12 + rd * 2**7 + op;
        rng = simm < -2048 || simm > 2047;
      end
      8: begin
        w   = ((imm / 32) % 128) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + (imm % 32) * 2**7 + op;
        rng = simm < -2048 || simm > 2047;
      end
      2: begin
        w   = ((imm / 4096) % 2) * 2**31 + ((imm / 32) % 64) * 2**25 + rs2 * 2**20 + rs1 * 2**15
              + f3 * 2**12 + ((imm / 2) % 16) * 2**8 + ((imm / 2048) % 2) * 2**7 + op;
        rng = simm < -4096 || simm > 4095 || (imm % 2) != 0;
      end
      4: begin
        w   = ((imm / 2**20) % 2) * 2**31 + ((imm / 2) % 1024) * 2**21 + ((imm / 2048) % 2) * 2**20
              + ((imm / 4096) % 256) * 2**12 + rd * 2**7 + op;
        rng = simm < -(2**20) || simm > 2**20 - 1 || (imm % 2) != 0;
      end
      5, 6: begin
        w   = (imm / 4096) * 4096 + rd * 2**7 + op;
        rng = (imm % 4096) != 0;
      end
      default: w = 32'h0;
    endcase
    err = (cls > 9) || (RANGE_EN && rng);
  endfunction

  task automatic set_bundle(input int cls, input int rd, input int rs1, input int rs2,
      input int f3, input int f7, input logic [31:0] imm);
    bus.in_class  = 4'(cls);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_imm    = imm;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = 0; count = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_bundle(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bus.out_valid, bus.out_err, bus.in_ready} !== 5'b0 ||
        bus.out_instr !== 32'h0 || bus.out_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b ov=%b err=%b ir=%b instr=%h addr=%h, want all 0",
               busy, done, bus.out_valid, bus.out_err, bus.in_ready, bus.out_instr, bus.out_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    pulse_start(32'h100, 16'd1);
    set_bundle(1, 1, 0, 0, 0, 0, 32'd5);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL single_ready: in_ready=%b busy=%b want 1 1", bus.in_ready, busy);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00500093 || bus.out_addr !== 32'h100 || bus.out_err !== 1'b0) begin
      errors++; $display("FAIL single_word: ov=%b instr=%h addr=%h err=%b want 1 00500093 00000100 0",
                         bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_done: done=%b ov=%b want 1 0", done, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h002081B3; exp_w[1] = 32'h00208463; exp_w[2] = 32'h123452B7;
    pulse_start(32'h0, 16'd3);
    bus.out_ready = 1'b1;
    set_bundle(0, 3, 1, 2, 0, 0, 32'h0);
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", k - 1, bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_w[k-1] || bus.out_addr !== 32'(4 * (k - 1))) begin
        errors++; $display("FAIL b2b_word[%0d]: ov=%b instr=%h addr=%h want 1 %h %h", k - 1,
                           bus.out_valid, bus.out_instr, bus.out_addr, exp_w[k-1], 32'(4 * (k - 1)));
      end
      if (k == 1) set_bundle(2, 0, 1, 2, 0, 0, 32'd8);
      else if (k == 2) set_bundle(6, 5, 0, 0, 0, 0, 32'h12345000);
      else bus.in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: done=%b want 1", done);
    end
  endtask

  task automatic test_backpressure;
    pulse_start(32'h200, 16'd2);
    set_bundle(4, 1, 0, 0, 0, 0, 32'h800);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    set_bundle(6, 5, 0, 0, 0, 0, 32'h12345000);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h001000EF || bus.out_addr !== 32'h200 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: ov=%b instr=%h addr=%h ir=%b want 1 001000ef 00000200 0",
                           i, bus.out_valid, bus.out_instr, bus.out_addr, bus.in_ready);
      end
      if (i == 1) begin
        start = 1'b1; base_addr = 32'hDEAD0000; count = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: in_ready=%b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h123452B7 || bus.out_addr !== 32'h204) begin
      errors++; $display("FAIL stall_second: ov=%b instr=%h addr=%h want 1 123452b7 00000204",
                         bus.out_valid, bus.out_instr, bus.out_addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_done: done=%b busy=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_illegal;
    pulse_start(32'h300, 16'd2);
    set_bundle(12, 7, 3, 4, 2, 32, 32'h123);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0 || bus.out_err !== 1'b1 || bus.out_addr !== 32'h300) begin
      errors++; $display("FAIL illegal_class: ov=%b instr=%h err=%b addr=%h want 1 00000000 1 00000300",
                         bus.out_valid, bus.out_instr, bus.out_err, bus.out_addr);
    end
    set_bundle(1, 1, 0, 0, 0, 0, 32'd2048);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_instr !== 32'h80000093 || bus.out_err !== RANGE_EN) begin
      errors++; $display("FAIL imm_range: instr=%h err=%b want 80000093 %b", bus.out_instr, bus.out_err, RANGE_EN);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL illegal_done: done=%b want 1", done);
    end
  endtask

  task automatic test_count_zero;
    bit seen;
    int waited;
    seen = 1'b0; waited = 0;
    pulse_start(32'h400, 16'd0);
    while (!seen && waited < 2) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL zero_no_output: ov=%b ir=%b want 0 0", bus.out_valid, bus.in_ready);
      end
      if (done === 1'b1) seen = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL zero_done: done=%b never pulsed, want 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid_burst;
    pulse_start(32'h0, 16'd4);
    set_bundle(0, 1, 2, 3, 0, 0, 32'h0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.out_instr !== 32'h0) begin
      errors++; $display("FAIL reset_mid: ov=%b busy=%b done=%b instr=%h want 0 0 0 00000000",
                         bus.out_valid, busy, done, bus.out_instr);
    end
    @(negedge clk);
    rst = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_no_done[%0d]: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_wrap;
    pulse_start(32'hFFFFFFFC, 16'd2);
    set_bundle(5, 2, 0, 0, 0, 0, 32'hABCDE000);
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_addr !== 32'hFFFFFFFC || bus.out_instr !== 32'hABCDE117) begin
      errors++; $display("FAIL wrap_first: addr=%h instr=%h want fffffffc abcde117", bus.out_addr, bus.out_instr);
    end
    set_bundle(8, 0, 1, 2, 2, 0, 32'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_addr !== 32'h0 || bus.out_instr !== 32'h0020A223) begin
      errors++; $display("FAIL wrap_second: addr=%h instr=%h want 00000000 0020a223", bus.out_addr, bus.out_instr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL wrap_done: done=%b want 1", done);
    end
  endtask

  task automatic test_random_bursts;
    for (int b = 0; b < 4; b++) begin
      exp_t        q [$];
      exp_t        e;
      exp_t        held;
      logic [31:0] base;
      logic [31:0] imm;
      int          n, sent, got, cyc, cls;
      bit          have, seen_done, stalled;
      base = $urandom & 32'hFFFFFFFC;
      n    = $urandom_range(5, 20);
      sent = 0; got = 0; cyc = 0; have = 1'b0; seen_done = 1'b0; stalled = 1'b0;
      held = '0;
      pulse_start(base, 16'(n));
      while (!seen_done && cyc < 2000) begin
        if (!have && sent < n) begin
          cls = $urandom_range(0, 11);
          case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
            2: imm = $urandom & 32'hFFFFF000;
            default: imm = $urandom_range(0, 31) * 2;
          endcase
          set_bundle(cls, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 7), $urandom_range(0, 127), imm);
          model_enc(cls, 32'(bus.in_rd), 32'(bus.in_rs1), 32'(bus.in_rs2), 32'(bus.in_funct3),
                    32'(bus.in_funct7), imm, e.instr, e.err);
          have = 1'b1;
        end
        bus.in_valid  = have && ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (stalled) begin
          checks++;
          if (bus.out_valid !== 1'b1 || {bus.out_instr, bus.out_addr, bus.out_err} !== held) begin
            errors++; $display("FAIL rnd_hold: ov=%b word=%h want 1 %h", bus.out_valid,
                               {bus.out_instr, bus.out_addr, bus.out_err}, held);
          end
        end
        if (done === 1'b1) begin
          seen_done = 1'b1;
          checks++;
          if (got != n || q.size() != 0) begin
            errors++; $display("FAIL rnd_done_early: got=%0d want %0d", got, n);
          end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL rnd_extra_word: got=%h want none", bus.out_instr);
          end else if ({bus.out_instr, bus.out_addr, bus.out_err} !== q[0]) begin
            errors++; $display("FAIL rnd_word[%0d]: instr=%h addr=%h err=%b want %h %h %b", got,
                               bus.out_instr, bus.out_addr, bus.out_err, q[0].instr, q[0].addr, q[0].err);
          end
          if (q.size() != 0) void'(q.pop_front());
          got++;
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
          e.addr = base + 32'(4 * sent);
          q.push_back(e);
          sent++;
          have = 1'b0;
        end
        stalled = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        held    = {bus.out_instr, bus.out_addr, bus.out_err};
        @(negedge clk);
        cyc++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (!seen_done) begin
        errors++; $display("FAIL rnd_timeout[%0d]: got=%0d words, no done, want %0d and done", b, got, n);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_illegal;
    test_count_zero;
    test_reset_mid_burst;
    test_wrap;
    test_random_bursts;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
